// File: rtl/mix_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mix_sequencer_if                                                |
// | Purpose  : Bundles the block-input and mix-selector handshakes between the |
// |            absorb source, the mix sequencer and the core round controller. |
// | Signals  : blk_data/blk_ds/blk_valid/blk_ready - input block handshake     |
// |            d/d_valid/d_ready/d_last           - mix selector handshake     |
// |            busy                               - block being sequenced      |
// | Modports : master - source/core side (drives block, consumes selectors)    |
// |            slave  - sequencer side                                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mix_sequencer_if #(
  parameter int CW  = 5,
  parameter int BLK = 128,
  parameter int DSW = 4
);
  logic [BLK-1:0]  blk_data;
  logic [DSW-1:0]  blk_ds;
  logic            blk_valid;
  logic            blk_ready;
  logic [2*CW-1:0] d;
  logic            d_valid;
  logic            d_ready;
  logic            d_last;
  logic            busy;

  modport master (
    output blk_data, blk_ds, blk_valid, d_ready,
    input  blk_ready, d, d_valid, d_last, busy
  );

  modport slave (
    input  blk_data, blk_ds, blk_valid, d_ready,
    output blk_ready, d, d_valid, d_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/mix_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mix_sequencer                                                   |
// | Purpose  : Accepts one absorbed block plus its domain-separation bits and  |
// |            serialises them, LSB first, into 2*CW-bit mix selectors, one    |
// |            per mix step, paced by a valid/ready handshake.                 |
// | Ports    : clk  - rising-edge clock                                        |
// |            rst  - synchronous active-high reset                            |
// |            bus  - mix_sequencer_if.slave (block in, selectors out, busy)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mix_sequencer #(
  parameter int CW  = 5,
  parameter int BLK = 128,
  parameter int DSW = 4
) (
  input wire logic       clk,
  input wire logic       rst,
  mix_sequencer_if.slave bus
);

  localparam int SELW  = 2 * CW;
  localparam int NSTEP = (BLK + DSW + SELW - 1) / SELW;
  localparam int SW    = NSTEP * SELW;
  localparam int CNTW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(NSTEP - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MIX  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] d_q, d_d;
  logic            d_last_q, d_last_d;
  logic            blk_ready_q, blk_ready_d;

  logic [SW-1:0]   load_w;
  logic            accept_w;
  logic            step_w;

  // Load image: block in the LSBs, domain bits directly above, zero pad on top.
  always_comb begin
    load_w              = '0;
    load_w[BLK-1:0]     = bus.blk_data;
    load_w[BLK +: DSW]  = bus.blk_ds;
  end

  // blk_ready_q is low for one cycle after reset even though the state is
  // IDLE, so accept must qualify on the registered ready, not the state alone.
  assign accept_w = (state_q == IDLE) && blk_ready_q && bus.blk_valid;
  assign step_w   = (state_q == MIX) && bus.d_ready;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    d_last_d    = d_last_q;
    blk_ready_d = blk_ready_q;
    case (state_q)
      IDLE: begin
        blk_ready_d = 1'b1;
        if (accept_w) begin
          state_d     = MIX;
          sreg_d      = load_w;
          cnt_d       = '0;
          d_d         = load_w[SELW-1:0];
          d_last_d    = (LAST_STEP == '0);
          blk_ready_d = 1'b0;
        end
      end
      MIX: begin
        if (step_w) begin
          if (cnt_q == LAST_STEP) begin
            state_d     = IDLE;
            d_d         = '0;
            d_last_d    = 1'b0;
            blk_ready_d = 1'b1;
          end else begin
            sreg_d   = sreg_q >> SELW;
            cnt_d    = cnt_q + CNTW'(1);
            // Present the next selector straight from the shifted image so
            // d stays a pure register output.
            d_d      = sreg_d[SELW-1:0];
            d_last_d = (cnt_d == LAST_STEP);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        d_d         = '0;
        d_last_d    = 1'b0;
        blk_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      d_q         <= '0;
      d_last_q    <= 1'b0;
      blk_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      d_last_q    <= d_last_d;
      blk_ready_q <= blk_ready_d;
    end
  end

  assign bus.d         = d_q;
  assign bus.d_last    = d_last_q;
  assign bus.blk_ready = blk_ready_q;
  assign bus.d_valid   = (state_q == MIX);
  assign bus.busy      = (state_q == MIX);

endmodule
`default_nettype wire

// File: tb/tb_mix_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mix_sequencer                                                |
// | Purpose  : Self-checking bench for mix_sequencer: reset, table vectors,    |
// |            backpressure, back-to-back blocks, mid-run reset and random     |
// |            blocks against a bit-slicing reference model.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mix_sequencer;

  localparam int CW    = 5;
  localparam int BLK   = 128;
  localparam int DSW   = 4;
  localparam int SELW  = 2 * CW;
  localparam int NSTEP = 14;

  localparam logic [127:0] PAT = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [SELW-1:0] obs_d [NSTEP];
  logic            obs_last [NSTEP];

  mix_sequencer_if #(.CW(CW), .BLK(BLK), .DSW(DSW)) bus ();

  mix_sequencer #(.CW(CW), .BLK(BLK), .DSW(DSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]    data;
    logic [3:0]      ds;
    int              mode;
    int              step;
    logic [SELW-1:0] exp_d;
    logic            exp_last;
  } vec_t;

  vec_t vecs [11];

  // Selector bit j of step k is bit k*SELW+j of the stream {pad, ds, data}.
  function automatic logic [SELW-1:0] model_sel(input logic [127:0] data,
                                                input logic [3:0] ds,
                                                input int step);
    logic [SELW-1:0] r;
    int b;
    for (int j = 0; j < SELW; j++) begin
      b = step * SELW + j;
      if (b < BLK)            r[j] = data[b];
      else if (b < BLK + DSW) r[j] = ds[b - BLK];
      else                    r[j] = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {bus.blk_ready, bus.d_valid, bus.d_last, bus.busy, 22'(bus.d)},
          {1'b1, 1'b0, 1'b0, 1'b0, 22'd0});
  endtask

  // Called at a negedge with the DUT idle. mode 0: d_ready always high,
  // mode 1: 5-cycle stall at step 4, mode 2: random d_ready.
  task automatic stream_block(input logic [127:0] data, input logic [3:0] ds,
                              input int mode, output int vcycles, output int hs);
    int  step;
    int  stall_left;
    int  guard;
    bit  done;
    bit  rdy;
    check("idle_ready_before_accept", bus.blk_ready, 1'b1);
    bus.blk_data  = data;
    bus.blk_ds    = ds;
    bus.blk_valid = 1'b1;
    bus.d_ready   = 1'b1;
    @(negedge clk);
    // Scramble the inputs after acceptance; only the accept-edge value counts.
    bus.blk_valid = 1'b0;
    bus.blk_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_ds    = 4'($urandom);
    step = 0; stall_left = 5; guard = 0; done = 0; vcycles = 0; hs = 0;
    while (!done && guard < 400) begin
      guard++;
      if (bus.d_valid !== 1'b1) begin
        check("d_valid_in_mix", bus.d_valid, 1'b1);
        done = 1;
      end else begin
        vcycles++;
        check($sformatf("d_step%0d", step), bus.d, model_sel(data, ds, step));
        check($sformatf("d_last_step%0d", step), bus.d_last, (step == NSTEP - 1));
        check("ready_busy_in_mix", {bus.blk_ready, bus.busy}, 2'b01);
        case (mode)
          0:       rdy = 1'b1;
          1: begin
            rdy = !(step == 4 && stall_left > 0);
            if (!rdy) stall_left--;
          end
          default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        bus.d_ready = rdy;
        if (rdy) begin
          obs_d[step]    = bus.d;
          obs_last[step] = bus.d_last;
          hs++;
          if (step == NSTEP - 1) done = 1;
          else step++;
        end
        @(negedge clk);
      end
    end
    if (guard >= 400) check("stream_timeout", 32'(guard), 32'd0);
    bus.d_ready = 1'b1;
    check_idle("idle_after_last");
  endtask

  initial begin
    int vc;
    int hs;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.blk_data  = '0;
    bus.blk_ds    = '0;
    bus.blk_valid = 1'b1;   // reset must win over a presented block
    bus.d_ready   = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {bus.blk_ready, bus.d_valid, bus.d_last, bus.busy, 22'(bus.d)}, 32'd0);
    end
    rst = 1'b0;
    bus.blk_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {bus.blk_ready, bus.d_valid}, 2'b10);
    @(negedge clk);
    check_idle("still_idle");

    // Table vectors.
    vecs[0]  = '{128'd0, 4'hC, 0, 0,  10'h000, 1'b0};
    vecs[1]  = '{128'd0, 4'hC, 0, 12, 10'h000, 1'b0};
    vecs[2]  = '{128'd0, 4'hC, 0, 13, 10'h003, 1'b1};
    vecs[3]  = '{'1,     4'h0, 0, 0,  10'h3FF, 1'b0};
    vecs[4]  = '{'1,     4'h0, 0, 11, 10'h3FF, 1'b0};
    vecs[5]  = '{'1,     4'h0, 0, 12, 10'h0FF, 1'b0};
    vecs[6]  = '{'1,     4'h0, 0, 13, 10'h000, 1'b1};
    vecs[7]  = '{PAT,    4'h5, 1, 0,  10'h210, 1'b0};
    vecs[8]  = '{PAT,    4'h5, 1, 4,  10'h0BA, 1'b0};
    vecs[9]  = '{PAT,    4'h5, 1, 12, 10'h101, 1'b0};
    vecs[10] = '{PAT,    4'h5, 1, 13, 10'h001, 1'b1};

    for (int v = 0; v < 11; v++) begin
      stream_block(vecs[v].data, vecs[v].ds, vecs[v].mode, vc, hs);
      check($sformatf("vec%0d_handshakes", v), 32'(hs), 32'(NSTEP));
      check($sformatf("vec%0d_valid_cycles", v), 32'(vc),
            (vecs[v].mode == 1) ? 32'(NSTEP + 5) : 32'(NSTEP));
      check($sformatf("vec%0d_table_d", v), obs_d[vecs[v].step], vecs[v].exp_d);
      check($sformatf("vec%0d_table_last", v), obs_last[vecs[v].step], vecs[v].exp_last);
    end

    // Back-to-back: blk_valid held high across two blocks.
    bus.blk_data  = PAT;
    bus.blk_ds    = 4'h9;
    bus.blk_valid = 1'b1;
    bus.d_ready   = 1'b1;
    @(negedge clk);
    bus.blk_data = ~PAT;
    bus.blk_ds   = 4'h6;
    for (int s = 0; s < NSTEP; s++) begin
      check("b2b_a_valid", {bus.d_valid, bus.blk_ready}, 2'b10);
      check($sformatf("b2b_a_d%0d", s), bus.d, model_sel(PAT, 4'h9, s));
      check("b2b_a_last", bus.d_last, (s == NSTEP - 1));
      @(negedge clk);
    end
    check("b2b_bubble", {bus.d_valid, bus.blk_ready}, 2'b01);
    @(negedge clk);
    bus.blk_valid = 1'b0;
    check("b2b_b_accept", {bus.d_valid, bus.blk_ready}, 2'b10);
    check("b2b_b_d0", bus.d, model_sel(~PAT, 4'h6, 0));
    for (int s = 1; s < NSTEP; s++) begin
      @(negedge clk);
      check($sformatf("b2b_b_d%0d", s), bus.d, model_sel(~PAT, 4'h6, s));
      check("b2b_b_last", bus.d_last, (s == NSTEP - 1));
    end
    @(negedge clk);
    check_idle("b2b_done");

    // Reset in the middle of a block.
    bus.blk_data  = PAT;
    bus.blk_ds    = 4'hF;
    bus.blk_valid = 1'b1;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    for (int s = 0; s <= 6; s++) begin
      check($sformatf("abort_d%0d", s), bus.d, model_sel(PAT, 4'hF, s));
      check("abort_no_last", bus.d_last, 1'b0);
      if (s < 6) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset_outputs", {bus.blk_ready, bus.d_valid, bus.d_last, bus.busy, 22'(bus.d)}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort_ready_again");
    stream_block(~PAT, 4'h3, 0, vc, hs);
    check("after_abort_handshakes", 32'(hs), 32'(NSTEP));

    // Random blocks with random backpressure.
    for (int r = 0; r < 20; r++) begin
      stream_block({$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 2, vc, hs);
      check("rand_handshakes", 32'(hs), 32'(NSTEP));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
